// File: rtl/phase_sweep_sequencer_if.sv
// Result stream from the sweep sequencer to the CSR/DMA side.
// A result is held stable while res_valid is high and is consumed when res_ready is also high.
interface phase_sweep_sequencer_if #(
  parameter int unsigned SW = 24
) ();

  logic                 res_valid;
  logic                 res_ready;
  logic [15:0]          res_index;
  logic signed [SW-1:0] res_sum_x;
  logic signed [SW-1:0] res_sum_y;

  modport master (
    output res_valid,
    output res_index,
    output res_sum_x,
    output res_sum_y,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_index,
    input  res_sum_x,
    input  res_sum_y,
    output res_ready
  );

endinterface

// File: rtl/phase_sweep_sequencer.sv
// Steps phase_inc_down through a programmed frequency sweep. For each point it discards a settle
// count of decimated strobes, then integrates 2^n I/Q samples and emits one result.
module phase_sweep_sequencer #(
  parameter int unsigned PW     = 19,
  parameter int unsigned DW     = 16,
  parameter int unsigned MAXLOG = 8,
  parameter int unsigned SW     = 24
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [PW-1:0]        cfg_start_inc,
  input  logic [PW-1:0]        cfg_step_inc,
  input  logic [15:0]          cfg_num_points,
  input  logic [7:0]           cfg_settle,
  input  logic [3:0]           cfg_avg_log2,
  input  logic                 ce_down,
  input  logic signed [DW-1:0] sample_x,
  input  logic signed [DW-1:0] sample_y,
  output logic [PW-1:0]        phase_inc_down,
  output logic                 busy,
  output logic                 done,
  phase_sweep_sequencer_if.master res
);

  // One extra bit so the count can reach 2^MAXLOG.
  localparam int unsigned CW = MAXLOG + 1;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StAccum,
    StEmit
  } state_e;

  state_e               state_q, state_d;
  logic [PW-1:0]        phase_q, phase_d;
  logic [15:0]          idx_q, idx_d;
  logic [7:0]           settle_cnt_q, settle_cnt_d;
  logic [CW-1:0]        sample_cnt_q, sample_cnt_d;
  logic signed [SW-1:0] sum_x_q, sum_x_d;
  logic signed [SW-1:0] sum_y_q, sum_y_d;
  logic                 valid_q, valid_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;

  // Configuration snapshot taken at start.
  logic [PW-1:0]        step_q, step_d;
  logic [15:0]          num_points_q, num_points_d;
  logic [7:0]           settle_q, settle_d;
  logic [3:0]           avg_log2_q, avg_log2_d;

  logic [3:0]           avg_log2_clamped;
  logic [CW-1:0]        sample_target;
  logic signed [SW-1:0] ext_x;
  logic signed [SW-1:0] ext_y;

  assign avg_log2_clamped = (cfg_avg_log2 > 4'(MAXLOG)) ? 4'(MAXLOG) : cfg_avg_log2;
  assign sample_target    = CW'(1) << avg_log2_q;
  assign ext_x            = SW'(sample_x);
  assign ext_y            = SW'(sample_y);

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    idx_d        = idx_q;
    settle_cnt_d = settle_cnt_q;
    sample_cnt_d = sample_cnt_q;
    sum_x_d      = sum_x_q;
    sum_y_d      = sum_y_q;
    valid_d      = valid_q;
    done_d       = 1'b0;
    step_d       = step_q;
    num_points_d = num_points_q;
    settle_d     = settle_q;
    avg_log2_d   = avg_log2_q;

    if (abort) begin
      // Abort wins over start, strobes and handshakes; phase is left where it was.
      state_d = StIdle;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            step_d       = cfg_step_inc;
            num_points_d = cfg_num_points;
            settle_d     = cfg_settle;
            avg_log2_d   = avg_log2_clamped;
            if (cfg_num_points == 16'd0) begin
              done_d = 1'b1;
            end else begin
              phase_d      = cfg_start_inc;
              idx_d        = 16'd0;
              settle_cnt_d = 8'd0;
              state_d      = StSettle;
            end
          end
        end
        StSettle: begin
          if (settle_cnt_q == settle_q) begin
            // A strobe in this cycle is neither counted nor accumulated.
            sum_x_d      = '0;
            sum_y_d      = '0;
            sample_cnt_d = '0;
            state_d      = StAccum;
          end else if (ce_down) begin
            settle_cnt_d = settle_cnt_q + 8'd1;
          end
        end
        StAccum: begin
          if (ce_down) begin
            sum_x_d      = sum_x_q + ext_x;
            sum_y_d      = sum_y_q + ext_y;
            sample_cnt_d = sample_cnt_q + CW'(1);
            if (sample_cnt_q + CW'(1) == sample_target) begin
              valid_d = 1'b1;
              state_d = StEmit;
            end
          end
        end
        StEmit: begin
          if (res.res_ready) begin
            valid_d = 1'b0;
            if (idx_q == num_points_q - 16'd1) begin
              done_d  = 1'b1;
              state_d = StIdle;
            end else begin
              idx_d        = idx_q + 16'd1;
              phase_d      = phase_q + step_q;
              settle_cnt_d = 8'd0;
              state_d      = StSettle;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q      <= StIdle;
      phase_q      <= '0;
      idx_q        <= '0;
      settle_cnt_q <= '0;
      sample_cnt_q <= '0;
      sum_x_q      <= '0;
      sum_y_q      <= '0;
      valid_q      <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      step_q       <= '0;
      num_points_q <= '0;
      settle_q     <= '0;
      avg_log2_q   <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      idx_q        <= idx_d;
      settle_cnt_q <= settle_cnt_d;
      sample_cnt_q <= sample_cnt_d;
      sum_x_q      <= sum_x_d;
      sum_y_q      <= sum_y_d;
      valid_q      <= valid_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      step_q       <= step_d;
      num_points_q <= num_points_d;
      settle_q     <= settle_d;
      avg_log2_q   <= avg_log2_d;
    end
  end

  assign phase_inc_down = phase_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign res.res_valid  = valid_q;
  assign res.res_index  = idx_q;
  assign res.res_sum_x  = sum_x_q;
  assign res.res_sum_y  = sum_y_q;

endmodule

// File: tb/tb_phase_sweep_sequencer.sv
// Directed bench for phase_sweep_sequencer: inputs change and outputs are checked on the falling
// edge, so every registered output has settled from the preceding rising edge.
module tb_phase_sweep_sequencer;

  localparam int unsigned PW = 19;
  localparam int unsigned DW = 16;
  localparam int unsigned SW = 24;

  logic                 sys_clk;
  logic                 rst;
  logic                 start;
  logic                 abort;
  logic [PW-1:0]        cfg_start_inc;
  logic [PW-1:0]        cfg_step_inc;
  logic [15:0]          cfg_num_points;
  logic [7:0]           cfg_settle;
  logic [3:0]           cfg_avg_log2;
  logic                 ce_down;
  logic signed [DW-1:0] sample_x;
  logic signed [DW-1:0] sample_y;
  logic [PW-1:0]        phase_inc_down;
  logic                 busy;
  logic                 done;

  int errors = 0;
  int checks = 0;

  phase_sweep_sequencer_if #(.SW(SW)) res_if ();

  phase_sweep_sequencer #(
    .PW(PW), .DW(DW), .MAXLOG(8), .SW(SW)
  ) dut (
    .sys_clk        (sys_clk),
    .rst            (rst),
    .start          (start),
    .abort          (abort),
    .cfg_start_inc  (cfg_start_inc),
    .cfg_step_inc   (cfg_step_inc),
    .cfg_num_points (cfg_num_points),
    .cfg_settle     (cfg_settle),
    .cfg_avg_log2   (cfg_avg_log2),
    .ce_down        (ce_down),
    .sample_x       (sample_x),
    .sample_y       (sample_y),
    .phase_inc_down (phase_inc_down),
    .busy           (busy),
    .done           (done),
    .res            (res_if)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(negedge sys_clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One-cycle decimated strobe carrying (x, y).
  task automatic strobe(input int x, input int y);
    ce_down  = 1'b1;
    sample_x = DW'(x);
    sample_y = DW'(y);
    tick();
    ce_down  = 1'b0;
  endtask

  task automatic configure(input int s_inc, input int st_inc, input int npts, input int settle,
                           input int avg);
    cfg_start_inc  = PW'(s_inc);
    cfg_step_inc   = PW'(st_inc);
    cfg_num_points = 16'(npts);
    cfg_settle     = 8'(settle);
    cfg_avg_log2   = 4'(avg);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int exp_phase [3];
    exp_phase[0] = 'h7FFF0;
    exp_phase[1] = 'h00010;
    exp_phase[2] = 'h00030;

    rst = 1'b1; start = 1'b0; abort = 1'b0; ce_down = 1'b0;
    sample_x = '0; sample_y = '0; res_if.res_ready = 1'b0;
    configure(0, 0, 0, 0, 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(res_if.res_valid), 0);
    check("rst_phase", 32'(phase_inc_down), 0);
    check("rst_done", 32'(done), 0);
    check("rst_sumx", 32'(res_if.res_sum_x), 0);

    // Single point, settle 2, four samples spaced four cycles apart.
    configure('h01000, 0, 1, 2, 2);
    pulse_start();
    configure(0, 0, 5, 9, 9);
    check("sp_busy", 32'(busy), 1);
    check("sp_phase", 32'(phase_inc_down), 'h01000);
    strobe(999, 999); tick(); tick(); tick();
    strobe(-999, 999); tick(); tick(); tick();
    strobe(100, -1); tick(); tick(); tick();
    strobe(-50, -1); tick(); tick(); tick();
    strobe(7, -1); tick(); tick(); tick();
    check("sp_valid_early", 32'(res_if.res_valid), 0);
    strobe(3, -1);
    check("sp_valid", 32'(res_if.res_valid), 1);
    tick(); tick(); tick();
    check("sp_sumx", 32'(res_if.res_sum_x), 60);
    check("sp_sumy", 32'(res_if.res_sum_y), -4);
    check("sp_index", 32'(res_if.res_index), 0);
    check("sp_done_hold", 32'(done), 0);
    res_if.res_ready = 1'b1;
    tick();
    res_if.res_ready = 1'b0;
    check("sp_done", 32'(done), 1);
    check("sp_busy_fall", 32'(busy), 0);
    check("sp_valid_fall", 32'(res_if.res_valid), 0);
    tick();
    check("sp_done_once", 32'(done), 0);

    // Phase wrap, settle 0, one sample per point, consumer always ready.
    configure('h7FFF0, 'h00020, 3, 0, 0);
    res_if.res_ready = 1'b1;
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      tick();
      strobe(k + 1, -(k + 1));
      check("wr_valid", 32'(res_if.res_valid), 1);
      check("wr_index", 32'(res_if.res_index), k);
      check("wr_phase", 32'(phase_inc_down), exp_phase[k]);
      check("wr_sumx", 32'(res_if.res_sum_x), k + 1);
      check("wr_sumy", 32'(res_if.res_sum_y), -(k + 1));
      tick();
    end
    check("wr_done", 32'(done), 1);
    check("wr_busy", 32'(busy), 0);
    res_if.res_ready = 1'b0;

    // Backpressure: result and phase hold for 50 cycles of live strobes.
    configure('h00100, 'h00010, 2, 1, 1);
    pulse_start();
    strobe(555, 555);
    tick();
    strobe(10, 20);
    strobe(-3, 5);
    ce_down = 1'b1; sample_x = 16'sd1000; sample_y = 16'sd1000;
    for (int i = 0; i < 50; i++) tick();
    ce_down = 1'b0;
    check("bp_valid", 32'(res_if.res_valid), 1);
    check("bp_sumx", 32'(res_if.res_sum_x), 7);
    check("bp_sumy", 32'(res_if.res_sum_y), 25);
    check("bp_index", 32'(res_if.res_index), 0);
    check("bp_phase", 32'(phase_inc_down), 'h00100);
    res_if.res_ready = 1'b1;
    tick();
    res_if.res_ready = 1'b0;
    check("bp_phase_step", 32'(phase_inc_down), 'h00110);
    check("bp_valid_fall", 32'(res_if.res_valid), 0);
    strobe(1000, 1000);
    tick();
    strobe(4, -4);
    strobe(6, -6);
    check("bp2_sumx", 32'(res_if.res_sum_x), 10);
    check("bp2_sumy", 32'(res_if.res_sum_y), -10);
    check("bp2_index", 32'(res_if.res_index), 1);
    res_if.res_ready = 1'b1;
    tick();
    res_if.res_ready = 1'b0;
    check("bp_done", 32'(done), 1);

    // Abort in SETTLE of point 1; a start while busy is ignored first.
    configure('h00200, 'h00040, 3, 2, 0);
    pulse_start();
    strobe(1, 1);
    strobe(2, 2);
    tick();
    strobe(5, 5);
    res_if.res_ready = 1'b1;
    tick();
    res_if.res_ready = 1'b0;
    check("ab_phase1", 32'(phase_inc_down), 'h00240);
    check("ab_index1", 32'(res_if.res_index), 1);
    configure('h00777, 'h00001, 9, 0, 0);
    pulse_start();
    check("ab_busy_start", 32'(busy), 1);
    check("ab_phase_start", 32'(phase_inc_down), 'h00240);
    check("ab_index_start", 32'(res_if.res_index), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_busy", 32'(busy), 0);
    check("ab_valid", 32'(res_if.res_valid), 0);
    check("ab_done", 32'(done), 0);
    check("ab_phase_hold", 32'(phase_inc_down), 'h00240);
    tick();
    check("ab_done_after", 32'(done), 0);

    // Abort together with start while in EMIT of another sweep.
    configure('h00300, 'h00010, 2, 0, 0);
    pulse_start();
    tick();
    strobe(1, 1);
    check("ae_valid", 32'(res_if.res_valid), 1);
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    check("ae_valid_fall", 32'(res_if.res_valid), 0);
    check("ae_busy", 32'(busy), 0);
    check("ae_done", 32'(done), 0);
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    check("ai_busy", 32'(busy), 0);
    check("ai_done", 32'(done), 0);
    check("ai_phase", 32'(phase_inc_down), 'h00300);

    // Zero points: done the cycle after start, never busy.
    configure('h00400, 'h00010, 0, 3, 1);
    pulse_start();
    check("np0_done", 32'(done), 1);
    check("np0_busy", 32'(busy), 0);
    tick();
    check("np0_done_once", 32'(done), 0);
    check("np0_busy2", 32'(busy), 0);

    // avg_log2=12 clamps to 8: 256 full-scale samples.
    configure('h00005, 0, 1, 0, 12);
    pulse_start();
    tick();
    ce_down = 1'b1; sample_x = 16'sh7FFF; sample_y = 16'sh8000;
    for (int i = 0; i < 255; i++) tick();
    check("cl_valid_255", 32'(res_if.res_valid), 0);
    tick();
    ce_down = 1'b0;
    check("cl_valid_256", 32'(res_if.res_valid), 1);
    check("cl_sumx", 32'(res_if.res_sum_x), 'h7FFF00);
    check("cl_sumy", 32'(res_if.res_sum_y), -8388608);
    res_if.res_ready = 1'b1;
    tick();
    res_if.res_ready = 1'b0;
    check("cl_done", 32'(done), 1);

    // Reset mid-accumulation, then a normal sweep.
    configure('h00123, 0, 2, 0, 2);
    pulse_start();
    tick();
    strobe(50, 50);
    check("rm_busy_pre", 32'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rm_busy", 32'(busy), 0);
    check("rm_phase", 32'(phase_inc_down), 0);
    check("rm_sumx", 32'(res_if.res_sum_x), 0);
    check("rm_valid", 32'(res_if.res_valid), 0);
    check("rm_done", 32'(done), 0);
    configure('h00040, 0, 1, 0, 0);
    pulse_start();
    tick();
    strobe(-7, 9);
    check("rm2_valid", 32'(res_if.res_valid), 1);
    check("rm2_sumx", 32'(res_if.res_sum_x), -7);
    check("rm2_phase", 32'(phase_inc_down), 'h00040);
    res_if.res_ready = 1'b1;
    tick();
    res_if.res_ready = 1'b0;
    check("rm2_done", 32'(done), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
